// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
//   Shared types and constants for the multiplexed hex 7-segment driver.
//
//   seg_t      : 7-bit segment vector {g,f,e,d,c,b,a}, bit = 1 means lit
//                (before any board polarity is applied).
//   SEG_OFF    : all segments dark, pre-polarity.
//   HEX_SEG    : glyph table for nibbles 0..F.
//   hex_lookup : table lookup helper used by the encoder.
// -----------------------------------------------------------------------------
package disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;

    localparam seg_t HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h67, 7'h77, 7'h7C,   // 8 9 A B
        7'h58, 7'h5E, 7'h79, 7'h71    // C D E F
    };

    function automatic seg_t hex_lookup(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/hex_seg_encode.sv
// -----------------------------------------------------------------------------
// hex_seg_encode
//   Combinational nibble-to-glyph encoder, polarity free (bit = 1 lit).
//
//   nibble  in  4  hex digit to display
//   dark    in  1  1 = force the glyph fully off
//   seg     out 7  {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_seg_encode
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dark,
    output seg_t       seg
);

    always_comb begin
        seg = dark ? SEG_OFF : hex_lookup(nibble);
    end

endmodule

// File: rtl/hex_display_scan.sv
// -----------------------------------------------------------------------------
// hex_display_scan
//   Time-multiplexed NUM_DIGITS-digit hex 7-segment driver. A packed value is
//   captured into a shadow register on load and promoted to the active
//   register only at a frame boundary, so one scan frame never mixes old and
//   new data. Each digit is held for SCAN_DIV cycles; the first cycle of every
//   dwell has all digit enables off to suppress ghosting between digits.
//   Supports leading-zero suppression and per-digit blanking.
//
//   Optional feature: define HEX_DISPLAY_BLINK_EN to add blink_mask and the
//   BLINK_FRAMES parameter; masked digits go dark on alternate blink phases.
//
//   Ports
//     clk         in   1            system clock
//     rst         in   1            synchronous active-high reset
//     load        in   1            strobe: capture value/blank_mask/lz_en
//     value       in   4*NUM_DIGITS packed nibbles, digit 0 in bits [3:0]
//     blank_mask  in   NUM_DIGITS   1 = force that digit dark
//     lz_en       in   1            1 = suppress leading zeros
//     blink_mask  in   NUM_DIGITS   (HEX_DISPLAY_BLINK_EN only) blink digits
//     segments    out  7            {g,f,e,d,c,b,a}, polarity SEG_ACTIVE_LOW
//     digit_sel   out  NUM_DIGITS   one-hot enable, polarity AN_ACTIVE_LOW
//     frame_done  out  1            pulse aligned with last digit's last cycle
// -----------------------------------------------------------------------------
module hex_display_scan
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
`ifdef HEX_DISPLAY_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 32
`endif
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
`ifdef HEX_DISPLAY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // Board polarity: active-low parts light a segment / digit with a 0.
    function automatic seg_t seg_pol(input seg_t s);
        return (SEG_ACTIVE_LOW != 0) ? ~s : s;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] sel_pol(input logic [NUM_DIGITS-1:0] s);
        return (AN_ACTIVE_LOW != 0) ? ~s : s;
    endfunction

    // Shadow (host side) and active (display side) copies of the inputs.
    logic [4*NUM_DIGITS-1:0] shadow_value, active_value;
    logic [NUM_DIGITS-1:0]   shadow_blank, active_blank;
    logic                    shadow_lz,    active_lz;

    logic [CNT_W-1:0] cnt_p0;
    logic [IDX_W-1:0] idx_p0;

    logic dwell_end;
    logic frame_end;

    assign dwell_end = (cnt_p0 == CNT_LAST);
    assign frame_end = dwell_end && (idx_p0 == IDX_LAST);

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int FCNT_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] shadow_blink, active_blink;
    logic [FCNT_W-1:0]     fcnt;
    logic                  blink_off;
`endif

    // Leading-zero detection: walk from the most significant digit down,
    // a digit is suppressible while every nibble at or above it is zero.
    logic [NUM_DIGITS-1:0] lz_dark;
    logic                  zero_run;

    always_comb begin
        lz_dark  = '0;
        zero_run = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            zero_run   = zero_run & (active_value[4*d +: 4] == 4'h0);
            lz_dark[d] = active_lz & zero_run & (d != 0);
        end
    end

    // Select the nibble, dark flag and enable for the digit being scanned.
    logic [3:0]            cur_nibble;
    logic                  cur_dark;
    logic [NUM_DIGITS-1:0] cur_onehot;

    always_comb begin
        cur_nibble = 4'h0;
        cur_dark   = 1'b0;
        cur_onehot = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx_p0 == IDX_W'(d)) begin
                cur_nibble    = active_value[4*d +: 4];
                cur_dark      = active_blank[d] | lz_dark[d]
`ifdef HEX_DISPLAY_BLINK_EN
                              | (active_blink[d] & blink_off)
`endif
                              ;
                cur_onehot[d] = 1'b1;
            end
        end
    end

    seg_t cur_seg;

    hex_seg_encode u_encode (
        .nibble (cur_nibble),
        .dark   (cur_dark),
        .seg    (cur_seg)
    );

    // Stage p0 -> p1: counter/index state to registered output pins.
    seg_t                  seg_p1;
    logic [NUM_DIGITS-1:0] sel_p1;
    logic                  fdone_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_blank <= '0;
            shadow_lz    <= 1'b0;
            active_value <= '0;
            active_blank <= '0;
            active_lz    <= 1'b0;
            cnt_p0       <= '0;
            idx_p0       <= '0;
            seg_p1       <= seg_pol(SEG_OFF);
            sel_p1       <= sel_pol('0);
            fdone_p1     <= 1'b0;
        end else begin
            if (load) begin
                shadow_value <= value;
                shadow_blank <= blank_mask;
                shadow_lz    <= lz_en;
            end

            // A load on the wrap cycle lands in shadow only; active takes
            // the previous shadow contents.
            if (dwell_end) begin
                cnt_p0 <= '0;
                if (idx_p0 == IDX_LAST) begin
                    idx_p0       <= '0;
                    active_value <= shadow_value;
                    active_blank <= shadow_blank;
                    active_lz    <= shadow_lz;
                end else begin
                    idx_p0 <= idx_p0 + IDX_W'(1);
                end
            end else begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            end

            seg_p1   <= seg_pol(cur_seg);
            sel_p1   <= (cnt_p0 == '0) ? sel_pol('0) : sel_pol(cur_onehot);
            fdone_p1 <= frame_end;
        end
    end

`ifdef HEX_DISPLAY_BLINK_EN
    // Blink phase flips every BLINK_FRAMES frames; reset lands in "on".
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_blink <= '0;
            active_blink <= '0;
            fcnt         <= '0;
            blink_off    <= 1'b0;
        end else begin
            if (load) begin
                shadow_blink <= blink_mask;
            end
            if (frame_end) begin
                active_blink <= shadow_blink;
                if (fcnt == FCNT_LAST) begin
                    fcnt      <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    fcnt <= fcnt + FCNT_W'(1);
                end
            end
        end
    end
`endif

    assign segments   = seg_p1;
    assign digit_sel  = sel_p1;
    assign frame_done = fdone_p1;

endmodule

// File: tb/tb_hex_display_scan.sv
module tb_hex_display_scan;

    localparam int ND  = 4;
    localparam int DIV = 4;
    localparam int FRAME = ND * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic        lz_en = 1'b0;
    logic [6:0]  segments;
    logic [3:0]  digit_sel;
    logic        frame_done;

    hex_display_scan #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (DIV),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .segments   (segments),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: edges since reset release plus shadow/active copies.
    int          e = 0;
    logic [15:0] m_sh_v, m_ac_v;
    logic [3:0]  m_sh_b, m_ac_b;
    logic        m_sh_lz, m_ac_lz;

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h67; 10: return 7'h77; 11: return 7'h7C;
           12: return 7'h58; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Active-low pin pattern expected for digit d of a displayed word.
    function automatic logic [6:0] exp_seg(input int d, input logic [15:0] v,
                                           input logic [3:0] b, input logic lz);
        int  upper;
        logic dark;
        upper = int'(v) >> (4 * d);
        dark  = b[d] || (lz && d > 0 && upper == 0);
        return dark ? 7'h7F : ~glyph(upper & 15);
    endfunction

    task automatic reset_tick();
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk); #1;
        checks++;
        assert (segments === 7'h7F) else begin
            errors++;
            $error("FAIL rst_seg got %h exp 7f", segments);
        end
        checks++;
        assert (digit_sel === 4'hF) else begin
            errors++;
            $error("FAIL rst_sel got %h exp f", digit_sel);
        end
        checks++;
        assert (frame_done === 1'b0) else begin
            errors++;
            $error("FAIL rst_fd got %b exp 0", frame_done);
        end
        m_sh_v = 16'h0; m_ac_v = 16'h0;
        m_sh_b = 4'h0;  m_ac_b = 4'h0;
        m_sh_lz = 1'b0; m_ac_lz = 1'b0;
        e = 0;
    endtask

    // One clock with optional load; checks the pins produced by that edge.
    task automatic tick(input logic ld, input logic [15:0] v,
                        input logic [3:0] b, input logic lz);
        int         c;
        int         idx;
        logic [3:0] esel;
        logic [6:0] eseg;
        rst = 1'b0;
        load = ld; value = v; blank_mask = b; lz_en = lz;
        @(posedge clk); #1;
        load = 1'b0;
        c    = e % DIV;
        idx  = (e / DIV) % ND;
        esel = (c == 0) ? 4'hF : ~(4'b0001 << idx);
        checks++;
        assert (digit_sel === esel) else begin
            errors++;
            $error("FAIL sel e=%0d got %h exp %h", e, digit_sel, esel);
        end
        checks++;
        assert (frame_done === (e % FRAME == FRAME - 1)) else begin
            errors++;
            $error("FAIL frame_done e=%0d got %b exp %b", e, frame_done, (e % FRAME == FRAME - 1));
        end
        if (c != 0) begin
            eseg = exp_seg(idx, m_ac_v, m_ac_b, m_ac_lz);
            checks++;
            assert (segments === eseg) else begin
                errors++;
                $error("FAIL seg e=%0d d%0d got %h exp %h", e, idx, segments, eseg);
            end
        end
        if (e % FRAME == FRAME - 1) begin
            m_ac_v = m_sh_v; m_ac_b = m_sh_b; m_ac_lz = m_sh_lz;
        end
        if (ld) begin
            m_sh_v = v; m_sh_b = b; m_sh_lz = lz;
        end
        e++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, value, blank_mask, lz_en);
    endtask

    // Idle until the next edge will be the one with e % FRAME == pos.
    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (e % FRAME) != pos; i++)
            tick(1'b0, value, blank_mask, lz_en);
    endtask

    initial begin
        logic [15:0] rv;
        logic [3:0]  rb;
        logic        rl;

        for (int i = 0; i < 3; i++) reset_tick();

        // Frame 0 shows the cleared "0000"; 12AF arrives in frame 1.
        tick(1'b1, 16'h12AF, 4'h0, 1'b0);
        idle(2 * FRAME - 1);

        tick(1'b1, 16'h0030, 4'h0, 1'b1);
        run_to(0);
        idle(FRAME);
        tick(1'b1, 16'h0000, 4'h0, 1'b1);
        run_to(0);
        idle(FRAME);

        tick(1'b1, 16'h8888, 4'b0100, 1'b0);
        run_to(0);
        idle(FRAME);

        // Two loads in one frame: last wins, and only from the next frame.
        run_to(3);
        tick(1'b1, 16'h1111, 4'h0, 1'b0);
        idle(4);
        tick(1'b1, 16'h2222, 4'h0, 1'b0);
        run_to(0);
        idle(FRAME);

        // Load exactly on the wrap edge is deferred one extra frame.
        run_to(FRAME - 1);
        tick(1'b1, 16'hC0DE, 4'h0, 1'b0);
        idle(2 * FRAME);

        // Randomized loads with mixed leading zeros, blanking and lz_en.
        for (int i = 0; i < 8 * FRAME; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                rv = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
                rb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                rl = 1'($urandom);
                tick(1'b1, rv, rb, rl);
            end else begin
                tick(1'b0, value, blank_mask, lz_en);
            end
        end

        // Reset during digit 2's dwell, with fresh data pending in shadow.
        run_to(0);
        tick(1'b1, 16'h5A5A, 4'h0, 1'b0);
        run_to(2 * DIV + 1);
        reset_tick();
        idle(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
- Multi-digit, time-multiplexed hexadecimal 7-segment display driver; next generation of the single-digit hex decoder.
- Latches a packed NUM_DIGITS x 4-bit value and scans digits one at a time over shared segment lines with one-hot digit enables.
- Adds frame-synchronous update, leading-zero suppression, per-digit blanking and an inter-digit ghost-blanking cycle.
- Sits between the debug/status datapath and the board's 7-segment bank.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; range 1..8.
- SCAN_DIV, 50000, clock cycles each digit is held (dwell); minimum 2.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when its bit is 0.
- AN_ACTIVE_LOW, 1, 1 = digit enabled when its digit_sel bit is 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- load  in  1  single-cycle strobe; captures value, blank_mask and lz_en.
- value  in  4*NUM_DIGITS  packed nibbles; digit 0 = bits [3:0] = least significant.
- blank_mask  in  NUM_DIGITS  1 = force that digit dark.
- lz_en  in  1  1 = suppress leading zeros.
- segments  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- digit_sel  out  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when the last digit's dwell ends.

Behaviour:
- Reset: all registers cleared; scan index = 0; dwell counter = 0. segments and digit_sel drive "all off" for the configured polarity (active-low: 7'h7F, all-ones). frame_done = 0.
- Registers:
  - Shadow register: captures inputs on any cycle with load=1.
  - Active register: copied from shadow only when the scan index wraps to 0 (frame boundary), so a frame never mixes old and new data.
  - Multiple loads within one frame: the last one wins.
  - Load in the same cycle as the wrap: the active register takes the pre-load shadow; the new data appears in the next frame.
- Dwell counter counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1: counter returns to 0 and the index advances. NUM_DIGITS-1 wraps to 0 and asserts frame_done for that cycle.
- Outputs are registered (1-cycle latency from counter/index to pins).
  - On counter==0 (first dwell cycle), digit_sel is all off (ghost blanking).
  - Cycles 1..SCAN_DIV-1 enable the digit at the current index.
- Encoding, 0..F, bit=1 lit before polarity:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:67, A:77, B:7C, C:58, D:5E, E:79, F:71.
- Digit d is dark (segments all off, digit_sel still enabled) if either holds:
  - blank_mask[d] = 1.
  - lz_en = 1, d > 0, and nibbles d..NUM_DIGITS-1 are all zero. Digit 0 is never zero-suppressed.
- NUM_DIGITS=1: index stays 0; frame_done pulses every SCAN_DIV cycles.
- Reset mid-scan: returns to reset state next edge; shadow and active registers are cleared (display shows blank/0s after reset per lz_en=0 → "0000").

Optional Feature:
- Macro: HEX_DISPLAY_BLINK_EN.
- Defined:
  - Extra ports blink_mask (in, NUM_DIGITS, captured on load like blank_mask) and parameter BLINK_FRAMES (default 32).
  - A frame counter toggles a blink phase every BLINK_FRAMES frames; the phase is reset to "on".
  - Digits with blink_mask=1 are dark during the "off" phase.
- Undefined: no blink ports, no frame counter; behaviour identical to the base spec.

Decomposition:
- Package disp_pkg:
  - seg_t (logic [6:0]) typedef.
  - SEG_OFF = 7'h00 (pre-polarity) constant.
  - Constant array HEX_SEG[16] holding the encoding table.
- Sub-module hex_seg_encode: combinational nibble + dark flag → seg_t, polarity-free. Instantiated once on the muxed nibble.
- Scan counter, index, shadow/active registers and output polarity in the top.

Test Plan:
- Reset, NUM_DIGITS=4, SCAN_DIV=4, active-low: hold rst 3 cycles → segments=7'h7F, digit_sel=4'hF, frame_done=0.
- load value=16'h12AF, lz_en=0 → after the next frame boundary, per digit: d0 seg 7'h0E with digit_sel 4'hE; d1 7'h08/4'hD; d2 7'h24/4'hB; d3 7'h79/4'h7. Each dwell's first cycle has digit_sel=4'hF. frame_done pulses every 16 cycles.
- lz_en=1, value=16'h0030 → d3 and d2 dark (7'h7F), d1 shows 7'h30, d0 shows 7'h40. value=16'h0000 → only d0 shows 7'h40.
- blank_mask=4'b0100 with value=16'h8888 → d2 dark, others 7'h00.
- Load 16'h1111 then 16'h2222 mid-frame → the current frame finishes the old data; the next frame shows 7'h24 on all digits, with no mixed frame.
- Assert rst during d2 dwell → next cycle all off, index 0; after release, the first frame shows "0000".
